// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: ready/valid write port, one-cycle launch
// pulses gated by the transmitter busy handshake, occupancy flags, sticky overflow and flush.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  localparam int PW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    flush,
  input  logic                    clr_overflow,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy,
  output logic [PW:0]             count,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic                    drained
);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [PW:0]             count_q;
  logic                    push;
  logic                    launch;
  logic                    overflow_set;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign wr_ready = !full;
  assign drained  = empty && !uart_tx_en && !uart_tx_busy;

  // Full is sampled from the register, so a same-cycle pop never rescues a write.
  assign push         = wr_en && !full && !flush;
  assign overflow_set = wr_en && full;
  // The !uart_tx_en term covers the cycle before the transmitter's busy rises.
  assign launch       = !empty && !uart_tx_busy && !uart_tx_en && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      overflow     <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PW'(1);
        if (launch) rd_ptr <= rd_ptr + PW'(1);
        case ({push, launch})
          2'b10:   count_q <= count_q + (PW+1)'(1);
          2'b01:   count_q <= count_q - (PW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
      uart_tx_en <= launch;
      if (launch) uart_tx_data <= mem[rd_ptr];
      if (overflow_set)      overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple transmitter model (fixed frame length)
// plus a force-busy override for holding the queue.
module tb_uart_tx_fifo;
  localparam int PB    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH);
  localparam int FRAME = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [PB-1:0] wr_data;
  logic          wr_ready;
  logic          flush;
  logic          clr_overflow;
  logic          uart_tx_en;
  logic [PB-1:0] uart_tx_data;
  logic          uart_tx_busy;
  logic [PW:0]   count;
  logic          empty, full, overflow, drained;

  logic          model_busy;
  logic          hold_busy;
  int            frame_cnt;

  int            errors = 0;
  int            checks = 0;
  int            launches = 0;
  int            cyc = 0;
  int            fall_cyc = 0;
  bit            fall_valid = 0;
  logic          prev_busy = 1'b0;
  logic          prev_en = 1'b0;
  logic [PB-1:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .clr_overflow(clr_overflow), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .drained(drained)
  );

  assign uart_tx_busy = model_busy | hold_busy;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Transmitter model: busy rises the cycle after the enable pulse, lasts FRAME cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      model_busy <= 1'b0;
      frame_cnt  <= 0;
    end else if (uart_tx_en) begin
      model_busy <= 1'b1;
      frame_cnt  <= FRAME - 1;
    end else if (model_busy) begin
      if (frame_cnt == 0) model_busy <= 1'b0;
      else frame_cnt <= frame_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_busy && !uart_tx_busy) begin
        fall_cyc   = cyc;
        fall_valid = 1;
      end
      if (prev_en && !uart_tx_en && fall_valid) begin
        chk("en_fall_gap_ge2", int'((cyc - fall_cyc) >= 2), 1);
        fall_valid = 0;
      end
      if (uart_tx_en) begin
        launches++;
        chk("en_single_cycle", int'(prev_en), 0);
        chk("launch_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("tx_data_order", int'(uart_tx_data), int'(exp_q.pop_front()));
      end
    end
    prev_busy = uart_tx_busy;
    prev_en   = uart_tx_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [PB-1:0] d);
    int n = 0;
    while (!wr_ready && n < 1000) begin
      step();
      n++;
    end
    if (!wr_ready) chk("wr_ready_timeout", 0, 1);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (!(drained && exp_q.size() == 0) && n < 3000) begin
      step();
      n++;
    end
    chk(tag, int'(drained && exp_q.size() == 0), 1);
  endtask

  initial begin
    int l0;
    resetn = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    clr_overflow = 1'b0; hold_busy = 1'b0;
    step(); step();
    resetn = 1'b1;

    // Reset state and idle
    chk("rst_tx_en", int'(uart_tx_en), 0);
    chk("rst_tx_data", int'(uart_tx_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drained", int'(drained), 1);
    repeat (4) step();
    chk("idle_no_launch", launches, 0);

    // Single byte: launch two cycles after the write
    write_byte(8'hA5);
    chk("single_count_n1", int'(count), 1);
    chk("single_en_n1", int'(uart_tx_en), 0);
    step();
    chk("single_en_n2", int'(uart_tx_en), 1);
    chk("single_data_n2", int'(uart_tx_data), 8'hA5);
    chk("single_count_n2", int'(count), 0);
    step();
    chk("single_en_n3", int'(uart_tx_en), 0);
    wait_drained("single_drain");
    chk("single_launches", launches, 1);

    // Burst with pointer wrap
    l0 = launches;
    for (int i = 0; i < 40; i++) write_byte(PB'(i));
    wait_drained("burst_drain");
    chk("burst_launches", launches - l0, 40);

    // Overflow with the transmitter held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = PB'(i);
      if (wr_ready) exp_q.push_back(PB'(i));
      step();
    end
    wr_en = 1'b0;
    chk("ovf_count", int'(count), DEPTH);
    chk("ovf_full", int'(full), 1);
    chk("ovf_wr_ready", int'(wr_ready), 0);
    chk("ovf_flag", int'(overflow), 1);
    wr_en = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b1;
    step();
    wr_en = 1'b0; clr_overflow = 1'b0;
    chk("ovf_set_beats_clr", int'(overflow), 1);
    chk("ovf_count_kept", int'(count), DEPTH);
    l0 = launches;
    hold_busy = 1'b0;
    wait_drained("ovf_drain");
    chk("ovf_launches", launches - l0, 16);

    // Flush coinciding with a launch opportunity and a write
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(PB'(8'h50 + i));
    chk("flush_pre_count", int'(count), 5);
    l0 = launches;
    hold_busy = 1'b0; flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    exp_q.delete();
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_no_en", int'(uart_tx_en), 0);
    chk("flush_overflow_kept", int'(overflow), 1);
    step();
    chk("flush_no_en_later", int'(uart_tx_en), 0);
    chk("flush_drained", int'(drained), 1);
    chk("flush_launches", launches - l0, 0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Simultaneous push and pop at count 3
    hold_busy = 1'b1;
    write_byte(8'h31); write_byte(8'h32); write_byte(8'h33);
    hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h34;
    exp_q.push_back(8'h34);
    step();
    wr_en = 1'b0;
    chk("pp_count", int'(count), 3);
    chk("pp_launch", int'(uart_tx_en), 1);
    chk("pp_data", int'(uart_tx_data), 8'h31);
    wait_drained("pp_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer that sits directly upstream of the UART transmitter. Accepts bytes from the CPU/peripheral bus side with a ready/valid write port, stores up to DEPTH entries, and launches them one at a time into the transmitter using its `uart_tx_en` / `uart_tx_busy` handshake. Also provides occupancy and status flags, a sticky overflow flag and a flush control.

## Interface
- PAYLOAD_BITS, 8, width of each entry; must match the transmitter's payload width.
- DEPTH, 16, number of entries; power of two, at least 2. Pointer width is PW = $clog2(DEPTH); count width is PW+1.
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- wr_en  input  1  write strobe; a byte is accepted when wr_en && wr_ready.
- wr_data  input  PAYLOAD_BITS  byte to enqueue.
- wr_ready  output  1  equals !full.
- flush  input  1  discards all queued entries this cycle.
- clr_overflow  input  1  clears the sticky overflow flag.
- uart_tx_en  output  1  registered one-cycle launch pulse to the transmitter.
- uart_tx_data  output  PAYLOAD_BITS  registered byte presented with uart_tx_en; holds its value between launches.
- uart_tx_busy  input  1  transmitter busy; high while a frame is in progress.
- count  output  PW+1  current number of queued entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a write is attempted while full.
- drained  output  1  empty && !uart_tx_en && !uart_tx_busy; nothing is queued or in flight.

## Operation
- Storage: DEPTH x PAYLOAD_BITS register array; rd_ptr and wr_ptr are PW bits wide and wrap naturally; count is held in a separate register.
- Write: when wr_en && !full (full sampled before any same-cycle pop), store wr_data at wr_ptr and increment wr_ptr.
- Write while full: the data is dropped, no state changes except overflow <= 1. A pop in the same cycle does not rescue the write.
- Launch condition: launch = !empty && !uart_tx_busy && !uart_tx_en && !flush.
  - On launch: uart_tx_data <= mem[rd_ptr], uart_tx_en <= 1, rd_ptr increments.
  - Otherwise uart_tx_en <= 0.
  - The `!uart_tx_en` term covers the cycle where the transmitter has sampled the enable but its busy output has not yet risen. This guarantees exactly one transmitter start per popped byte.
- Count update: count <= count + push - pop; a simultaneous push and pop leaves count unchanged.
- Flush: rd_ptr, wr_ptr and count are set to 0, and any same-cycle write and launch are suppressed.
  - Flush does not affect a byte already handed to the transmitter; a uart_tx_en pulse already asserted this cycle still completes.
  - overflow is unaffected by flush.
- Overflow: set has priority over clear when clr_overflow and an overflowing write occur in the same cycle.
- Reset (resetn == 0 at a clock edge):
  - Pointers and count are cleared.
  - Output values: uart_tx_en = 0, uart_tx_data = 0, count = 0, empty = 1, full = 0, wr_ready = 1, overflow = 0, drained = 1 (assuming uart_tx_busy = 0).
  - Memory contents are not reset.
  - A mid-operation reset discards everything; the transmitter shares resetn and aborts too.

## Timing
- Write accepted at edge N: count, empty and full reflect it after edge N.
- Earliest launch decision is in cycle N+1, so uart_tx_en is high in cycle N+2. Fill-to-launch latency is 2 cycles.
- uart_tx_en is high for exactly 1 cycle per launch.
- Transmitter busy rises the cycle after the uart_tx_en cycle. The next launch is decided the first cycle busy is low again, so back-to-back frames have a 2-cycle gap between busy falling and the next uart_tx_en.
- Flags are combinational from the count register. wr_ready is therefore valid from the start of each cycle and does not depend on wr_en.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering must hold across any number of wraps.

## Test plan
- Reset then idle: hold resetn low for 2 cycles, release. Required: uart_tx_en = 0, count = 0, empty = 1, wr_ready = 1, drained = 1, and no launch while empty.
- Single byte: write 0xA5 at cycle 0 with busy = 0. Required: uart_tx_en high exactly at cycle 2 with uart_tx_data = 0xA5, and count back to 0 after cycle 1. With a transmitter model driving busy high 1 cycle later, there is no second pulse.
- Burst with wrap: write 40 incrementing bytes (0x00..0x27) with DEPTH = 16, honouring wr_ready, against a transmitter model of 10 cycles/frame. Required: exactly 40 launches in order 0x00..0x27, and each uart_tx_en falls at least 2 cycles after busy falls.
- Overflow: with busy held high, write 17 bytes unconditionally. Required:
  - count = 16, full = 1, overflow = 1.
  - Releasing busy launches bytes 0..15 only.
  - clr_overflow clears the flag; clr_overflow asserted together with another full write leaves it set.
- Flush: queue 5 bytes, then assert flush in the same cycle as a launch opportunity and a write. Required: no launch, count = 0 the next cycle, the write is dropped, and overflow is unchanged.
- Simultaneous push/pop at count = 3: the launch pops while wr_en is high. Required: count stays 3, and the pushed byte is emitted fourth in order.
